// File: rtl/speed_pi_pwm.sv
// Speed-loop PI controller driving a single PWM output.
// One control update per sample window, sequenced over four single-clock steps.
module speed_pi_pwm #(
    parameter int SAMPLE_DIV = 131072,
    parameter int PWM_MAX    = 1000,
    parameter int KP_SHIFT   = 2,
    parameter int KI_SHIFT   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [15:0] i_setpoint,
    input  logic [15:0] i_velocity,
    output logic        o_pwm,
    output logic [15:0] o_duty,
    output logic        o_update,
    output logic        o_sat
);

    localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [SW-1:0]       SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [15:0]         PWM_LAST    = 16'(PWM_MAX - 1);
    localparam logic signed [18:0]  DUTY_MAX    = 19'(PWM_MAX);

    typedef enum logic [2:0] {IDLE, CAPTURE, ERROR, INTEG, OUTPUT} state_t;

    function automatic logic [15:0] clamp_duty(input logic signed [18:0] v);
        if (v < 19'sd0)
            return 16'd0;
        else if (v > DUTY_MAX)
            return 16'(PWM_MAX);
        else
            return v[15:0];
    endfunction

    function automatic logic is_clamped(input logic signed [18:0] v);
        return (v < 19'sd0) || (v > DUTY_MAX);
    endfunction

    state_t             state, state_next;
    logic [SW-1:0]      samp_cnt;
    logic               tick;
    logic               cap_en, err_en, integ_en, out_en;
    logic [15:0]        sp_q, vel_q;
    logic signed [16:0] err_q;
    logic [15:0]        integ;
    logic signed [16:0] err_d;
    logic signed [18:0] err_x, integ_x, integ_sum, u_sum;
    logic [15:0]        pwm_cnt, shadow, duty_now;

    // Sample window counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            samp_cnt <= '0;
        else if (!i_enable || samp_cnt == SAMPLE_LAST)
            samp_cnt <= '0;
        else
            samp_cnt <= samp_cnt + SW'(1);
    end

    assign tick = i_enable && (samp_cnt == SAMPLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (!i_enable)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = CAPTURE;
            CAPTURE: state_next = ERROR;
            ERROR:   state_next = INTEG;
            INTEG:   state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cap_en   = 1'b0;
        err_en   = 1'b0;
        integ_en = 1'b0;
        out_en   = 1'b0;
        case (state)
            CAPTURE: cap_en   = 1'b1;
            ERROR:   err_en   = 1'b1;
            INTEG:   integ_en = 1'b1;
            OUTPUT:  out_en   = 1'b1;
            default: ;
        endcase
    end

    // Operands are zero-extended, so the 17-bit difference cannot overflow
    assign err_d     = $signed({1'b0, sp_q}) - $signed({1'b0, vel_q});
    assign err_x     = {{2{err_q[16]}}, err_q};
    assign integ_x   = {3'b000, integ};
    assign integ_sum = integ_x + (err_x >>> KI_SHIFT);
    assign u_sum     = integ_x + (err_x >>> KP_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q     <= '0;
            vel_q    <= '0;
            err_q    <= '0;
            integ    <= '0;
            o_duty   <= '0;
            o_sat    <= 1'b0;
            o_update <= 1'b0;
        end else if (!i_enable) begin
            integ    <= '0;
            o_duty   <= '0;
            o_sat    <= 1'b0;
            o_update <= 1'b0;
        end else begin
            o_update <= 1'b0;
            if (cap_en) begin
                sp_q  <= i_setpoint;
                vel_q <= i_velocity;
            end
            if (err_en)
                err_q <= err_d;
            // Integrator clamp is the anti-windup; it does not flag o_sat
            if (integ_en)
                integ <= clamp_duty(integ_sum);
            if (out_en) begin
                o_duty   <= clamp_duty(u_sum);
                o_sat    <= is_clamped(u_sum);
                o_update <= 1'b1;
            end
        end
    end

    // At the period start compare against the duty being loaded, so the first
    // clock of each period already reflects the new shadow value.
    assign duty_now = (pwm_cnt == 16'd0) ? o_duty : shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            shadow  <= '0;
            o_pwm   <= 1'b0;
        end else if (!i_enable) begin
            pwm_cnt <= '0;
            shadow  <= '0;
            o_pwm   <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? 16'd0 : pwm_cnt + 16'd1;
            if (pwm_cnt == 16'd0)
                shadow <= o_duty;
            o_pwm <= (pwm_cnt < duty_now);
        end
    end

endmodule

// File: tb/tb_speed_pi_pwm.sv
// Bench for speed_pi_pwm: vector table, directed corner sequences and a
// randomized run compared every clock against a behavioural reference model.
module tb_speed_pi_pwm;

    localparam int SD = 16;
    localparam int PM = 100;
    localparam int KP = 2;
    localparam int KI = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] sp, vel;
    logic        o_pwm, o_update, o_sat;
    logic [15:0] o_duty;

    int checks   = 0;
    int failures = 0;

    speed_pi_pwm #(.SAMPLE_DIV(SD), .PWM_MAX(PM), .KP_SHIFT(KP), .KI_SHIFT(KI)) dut (
        .clk(clk), .rst(rst), .i_enable(en), .i_setpoint(sp), .i_velocity(vel),
        .o_pwm(o_pwm), .o_duty(o_duty), .o_update(o_update), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int floor_div(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > PM) return PM;
        return v;
    endfunction

    int m_samp, m_age, m_sp, m_vel, m_integ, m_duty, m_sat, m_upd, m_pcnt, m_shadow, m_pwm;

    task automatic model_clear();
        m_samp = 0; m_age = 0; m_integ = 0; m_duty = 0; m_sat = 0;
        m_upd = 0; m_pcnt = 0; m_shadow = 0; m_pwm = 0;
    endtask

    // m_age counts clocks since the tick: inputs are taken one clock after the
    // tick edge, results appear on the fourth clock after it.
    task automatic model_step();
        int old_age, e, u;
        if (m_pcnt == 0) m_shadow = m_duty;
        m_pwm  = (m_pcnt < m_shadow) ? 1 : 0;
        m_pcnt = (m_pcnt + 1) % PM;
        m_upd  = 0;
        old_age = m_age;
        if (old_age == 1) begin
            m_sp  = int'(sp);
            m_vel = int'(vel);
        end
        if (old_age == 4) begin
            e       = m_sp - m_vel;
            m_integ = clampi(m_integ + floor_div(e, 1 << KI));
            u       = floor_div(e, 1 << KP) + m_integ;
            m_duty  = clampi(u);
            m_sat   = (u < 0 || u > PM) ? 1 : 0;
            m_upd   = 1;
            m_age   = 0;
        end else if (old_age > 0)
            m_age = old_age + 1;
        else if (m_samp == SD - 1)
            m_age = 1;
        m_samp = (m_samp + 1) % SD;
    endtask

    always @(posedge clk) begin
        if (rst || !en) model_clear();
        else model_step();
        #1;
        check("model_duty",   o_duty,   m_duty);
        check("model_sat",    o_sat,    m_sat);
        check("model_update", o_update, m_upd);
        check("model_pwm",    o_pwm,    m_pwm);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_update(output int cyc);
        cyc = 0;
        while (cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (o_update === 1'b1) break;
        end
    endtask

    task automatic fresh_start(input int s, input int v);
        @(negedge clk); en = 1'b0;
        @(negedge clk); sp = 16'(s); vel = 16'(v); en = 1'b1;
    endtask

    typedef struct {
        bit fresh;
        int sp;
        int vel;
        int duty;
        int sat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        int lat, hi0, hi1, ups;
        rst = 1'b1; en = 1'b0; sp = '0; vel = '0;

        vecs = '{
            '{1,    40,     0,  12, 0},
            '{0,    40,     0,  14, 0},
            '{0,   200,   200,   4, 0},
            '{0,   200,   200,   4, 0},
            '{0,    10,    14,   2, 0},
            '{1,   400,     0, 100, 1},
            '{0,   400,     0, 100, 1},
            '{1,     0,   300,   0, 1},
            '{0,     0,   300,   0, 1},
            '{1,   200,   200,   0, 0},
            '{1, 65535,     0, 100, 1},
            '{1,     0, 65535,   0, 1},
            '{1,    40,     0,  12, 0},
            '{0,     0,    20,   0, 1},
            '{1,   120,   100,   6, 0},
            '{1,   320,     0, 100, 0},
            '{1,   321,     0, 100, 0},
            '{1,   324,     0, 100, 1}
        };

        // Reset state
        @(negedge clk);
        check("rst_pwm", o_pwm, 0);
        check("rst_duty", o_duty, 0);
        check("rst_update", o_update, 0);
        check("rst_sat", o_sat, 0);
        @(negedge clk); rst = 1'b0;

        // Vector table: each row is one control update
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].fresh) fresh_start(vecs[i].sp, vecs[i].vel);
            else begin
                @(negedge clk); sp = 16'(vecs[i].sp); vel = 16'(vecs[i].vel);
            end
            wait_update(lat);
            // Counter starts at 0 on enable, ticks at SD-1, result 5 clocks later
            check($sformatf("vec%0d_latency", i), lat, vecs[i].fresh ? SD + 4 : SD);
            check($sformatf("vec%0d_duty", i), o_duty, vecs[i].duty);
            check($sformatf("vec%0d_sat", i), o_sat, vecs[i].sat);
        end

        // PWM shadow: first period uses duty 0, second period the settled duty 4
        fresh_start(40, 0);
        hi0 = 0; hi1 = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c <= 100) hi0 += int'(o_pwm); else hi1 += int'(o_pwm);
            if (c == 20) check("seqB_duty1", o_duty, 12);
            if (c == 36) begin
                check("seqB_duty2", o_duty, 14);
                sp = 16'd200; vel = 16'd200;
            end
            if (c == 52) check("seqB_duty3", o_duty, 4);
        end
        check("seqB_high_period0", hi0, 0);
        check("seqB_high_period1", hi1, 4);

        // Saturated high, then disable while the update is in its INTEG step
        fresh_start(400, 0);
        hi1 = 0;
        for (int c = 1; c <= 114; c++) begin
            @(posedge clk); #1;
            if (c > 100) hi1 += int'(o_pwm);
        end
        check("seqC_pwm_full", hi1, 14);
        en = 1'b0;
        @(posedge clk); #1;
        check("seqC_dis_pwm", o_pwm, 0);
        check("seqC_dis_duty", o_duty, 0);
        check("seqC_dis_sat", o_sat, 0);
        ups = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            ups += int'(o_update);
        end
        check("seqC_no_update", ups, 0);
        @(negedge clk); sp = 16'd40; vel = 16'd0; en = 1'b1;
        wait_update(lat);
        check("seqC_reen_latency", lat, SD + 4);
        check("seqC_reen_duty", o_duty, 12);

        // Reset in the middle of a saturated PWM period
        fresh_start(400, 0);
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk); #1;
        end
        check("seqD_pwm_before", o_pwm, 1);
        @(negedge clk); rst = 1'b1; sp = 16'd40;
        #1;
        check("seqD_rst_pwm", o_pwm, 0);
        check("seqD_rst_duty", o_duty, 0);
        check("seqD_rst_update", o_update, 0);
        check("seqD_rst_sat", o_sat, 0);
        @(negedge clk); rst = 1'b0;
        wait_update(lat);
        check("seqD_latency", lat, SD + 4);
        check("seqD_duty", o_duty, 12);

        // Randomized run; the per-clock model comparison does the checking
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = 1'b0;
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            else if (en && $urandom_range(0, 299) == 0) en = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    sp  = 16'($urandom);
                    vel = 16'($urandom);
                end else begin
                    sp  = 16'($urandom_range(0, 400));
                    vel = 16'($urandom_range(0, 400));
                end
            end
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
